gpio_in_debounce: RTL and testbench

//   Input-side conditioner for the MIPS GPIO_i port: synchronizes raw slide-switch levels,

---
 rtl/gpio_in_debounce.sv | 97 +++++++++
 tb/tb_gpio_in_debounce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// Switch-input conditioner: 2-FF synchronizer, per-bit debounce, edge pulses and sticky rise flags.
// Latency: a level change that holds reaches gpio_o CNT_MAX+2 edges after it is first sampled.
// No backpressure: inputs are sampled every cycle and the outputs are plain registered levels/pulses.
module gpio_in_debounce #(
    parameter int WIDTH   = 8,
    parameter int CNT_MAX = 500000,
    parameter int CNT_W   = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] rise_flag_o,
    output logic             changed_o
);

    // Terminal count: a disagreement seen on this count value is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronizer stages; s2 is the only copy of the switches the debounce logic looks at.
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Independent stability counter per bit.
    logic [CNT_W-1:0] cnt [WIDTH];

    // Bits whose new level is accepted at the coming edge, split by direction.
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise_event;
    logic [WIDTH-1:0] fall_event;

    // Two-stage synchronizer for the asynchronous switch levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_i;
            s2 <= s1;
        end
    end

    // A bit is accepted when it still disagrees and has already disagreed CNT_MAX-1 cycles.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != gpio_o[i]) && (cnt[i] == CNT_LAST);
        end
        // On accept the new level is s2, so its value alone gives the direction.
        rise_event = accept & s2;
        fall_event = accept & ~s2;
    end

    // Per-bit counters: any agreement restarts, a disagreement counts up to the terminal value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!reset) begin
                cnt[i] <= '0;
            end else if (s2[i] == gpio_o[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + CNT_ONE;
            end
        end
    end

    // Debounced level and edge pulses update on the same edge, so pulses line up with gpio_o.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_o    <= '0;
            rise_o    <= '0;
            fall_o    <= '0;
            changed_o <= 1'b0;
        end else begin
            gpio_o    <= (gpio_o & ~accept) | (s2 & accept);
            rise_o    <= rise_event;
            fall_o    <= fall_event;
            changed_o <= |accept;
        end
    end

    // Sticky rise record; a new rise wins over a clear requested in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rise_flag_o <= '0;
        end else begin
            rise_flag_o <= (rise_flag_o & ~clr_i) | rise_event;
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with CNT_MAX=4, WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Ends with one summary line of check and error counts.
module tb_gpio_in_debounce;

    logic       clk;
    logic       reset;
    logic [7:0] sw_i;
    logic [7:0] clr_i;
    logic [7:0] gpio_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic [7:0] rise_flag_o;
    logic       changed_o;

    int n_checks;
    int n_errors;

    gpio_in_debounce #(
        .WIDTH   (8),
        .CNT_MAX (4),
        .CNT_W   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_i        (sw_i),
        .clr_i       (clr_i),
        .gpio_o      (gpio_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .rise_flag_o (rise_flag_o),
        .changed_o   (changed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [4:0] bounce_pat;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        sw_i     = 8'hFF;
        clr_i    = 8'h00;
        bounce_pat = 5'b10101;

        // Reset with all switches high: everything held at zero.
        step(3);
        chk("rst_gpio", gpio_o, 8'h00);
        chk("rst_rise", rise_o, 8'h00);
        chk("rst_fall", fall_o, 8'h00);
        chk("rst_flag", rise_flag_o, 8'h00);
        chk("rst_chg", {7'd0, changed_o}, 8'h00);
        reset = 1'b1;
        // 2 sync edges + 4 stable edges: level appears on the 6th edge after release.
        step(5);
        chk("rel_gpio_e5", gpio_o, 8'h00);
        step(1);
        chk("rel_gpio_e6", gpio_o, 8'hFF);
        chk("rel_rise_e6", rise_o, 8'hFF);
        chk("rel_chg_e6", {7'd0, changed_o}, 8'h01);
        chk("rel_flag_e6", rise_flag_o, 8'hFF);
        step(1);
        chk("rel_rise_e7", rise_o, 8'h00);
        chk("rel_chg_e7", {7'd0, changed_o}, 8'h00);
        chk("rel_gpio_e7", gpio_o, 8'hFF);

        // Back to an all-zero state.
        reset = 1'b0;
        sw_i  = 8'h00;
        step(2);
        reset = 1'b1;
        step(2);

        // Glitch of 3 cycles is rejected.
        sw_i = 8'h01;
        step(3);
        sw_i = 8'h00;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("glitch3_gpio", gpio_o, 8'h00);
            chk("glitch3_rise", rise_o, 8'h00);
        end

        // 4-cycle pulse is accepted, then falls back after release.
        sw_i = 8'h01;
        step(4);
        sw_i = 8'h00;
        step(1);
        chk("p4_gpio_e5", gpio_o, 8'h00);
        step(1);
        chk("p4_gpio_e6", gpio_o, 8'h01);
        chk("p4_rise_e6", rise_o, 8'h01);
        chk("p4_chg_e6", {7'd0, changed_o}, 8'h01);
        step(1);
        chk("p4_rise_e7", rise_o, 8'h00);
        chk("p4_gpio_e7", gpio_o, 8'h01);
        step(2);
        chk("p4_gpio_e9", gpio_o, 8'h01);
        chk("p4_fall_e9", fall_o, 8'h00);
        step(1);
        chk("p4_gpio_e10", gpio_o, 8'h00);
        chk("p4_fall_e10", fall_o, 8'h01);
        chk("p4_rise_e10", rise_o, 8'h00);
        chk("p4_chg_e10", {7'd0, changed_o}, 8'h01);
        step(1);
        chk("p4_fall_e11", fall_o, 8'h00);

        // Clear all flags.
        clr_i = 8'hFF;
        step(1);
        clr_i = 8'h00;
        chk("clr_all", rise_flag_o, 8'h00);

        // Bounce on bit 3: 1,0,1,0,1 then hold 1.
        for (int k = 4; k >= 0; k--) begin
            sw_i = {4'd0, bounce_pat[k], 3'd0};
            step(1);
            chk("bnc_rise_toggle", rise_o, 8'h00);
        end
        step(4);
        chk("bnc_gpio_pre", gpio_o, 8'h00);
        chk("bnc_rise_pre", rise_o, 8'h00);
        step(1);
        chk("bnc_gpio", gpio_o, 8'h08);
        chk("bnc_rise", rise_o, 8'h08);
        step(1);
        chk("bnc_rise_after", rise_o, 8'h00);
        chk("bnc_gpio_after", gpio_o, 8'h08);

        // Sticky flag on bit 2 and clear.
        clr_i = 8'hFF;
        step(1);
        clr_i = 8'h00;
        chk("stk_clr0", rise_flag_o, 8'h00);
        sw_i = 8'h0C;
        step(6);
        chk("stk_rise", rise_o, 8'h04);
        chk("stk_flag_set", rise_flag_o, 8'h04);
        step(3);
        chk("stk_flag_hold", rise_flag_o, 8'h04);
        chk("stk_gpio", gpio_o, 8'h0C);
        clr_i = 8'h04;
        step(1);
        clr_i = 8'h00;
        chk("stk_flag_clr", rise_flag_o, 8'h00);
        step(1);
        chk("stk_flag_stay0", rise_flag_o, 8'h00);
        sw_i = 8'h08;
        step(6);
        chk("stk_fall2", fall_o, 8'h04);
        chk("stk_flag_nofall", rise_flag_o, 8'h00);
        step(1);
        // New rise with clear asserted on the same edge: set wins.
        sw_i = 8'h0C;
        step(5);
        chk("stk_pre_rise", rise_o, 8'h00);
        clr_i = 8'h04;
        step(1);
        chk("stk_rise2", rise_o, 8'h04);
        chk("stk_set_wins", rise_flag_o, 8'h04);
        step(1);
        chk("stk_clr_held", rise_flag_o, 8'h00);
        clr_i = 8'h00;

        // Return to zero, then multi-bit change interrupted by reset at count 2.
        sw_i = 8'h00;
        step(6);
        chk("mb_fall", fall_o, 8'h0C);
        chk("mb_gpio0", gpio_o, 8'h00);
        step(1);
        sw_i = 8'h81;
        step(4);
        reset = 1'b0;
        step(1);
        chk("mb_rst_gpio", gpio_o, 8'h00);
        chk("mb_rst_rise", rise_o, 8'h00);
        chk("mb_rst_chg", {7'd0, changed_o}, 8'h00);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("mb_restart_gpio", gpio_o, 8'h00);
            chk("mb_restart_rise", rise_o, 8'h00);
        end
        step(1);
        chk("mb_gpio", gpio_o, 8'h81);
        chk("mb_rise", rise_o, 8'h81);
        chk("mb_fall0", fall_o, 8'h00);
        chk("mb_chg", {7'd0, changed_o}, 8'h01);
        chk("mb_flag", rise_flag_o, 8'h81);
        step(1);
        chk("mb_rise_end", rise_o, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
